// File: rtl/dff_pkg.sv
// Shared types for the dff block's input conditioner.
//  cond_state_t : debounce FSM state (idle at a committed level, or checking
//                 a candidate new level)
//  GLITCH_W     : width of the rejected-pulse counter
//  sat_inc      : saturating increment for the glitch counter
package dff_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } cond_state_t;

    localparam int GLITCH_W = 8;

    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dff_sync_chain.sv
// Flop-chain synchronizer for an asynchronous single-bit input.
//  clk   in  rising-edge clock
//  reset in  asynchronous, active-high; loads every stage with RESET_VAL
//  din   in  asynchronous input
//  dout  out last stage; a din change sampled at edge 1 appears after edge STAGES
module dff_sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= {STAGES{RESET_VAL}};
        else       q <= {q[STAGES-2:0], din};
    end

    assign dout = q[STAGES-1];

endmodule

// File: rtl/d_input_conditioner.sv
// Conditions a raw, bouncy asynchronous input into a clean synchronous level
// for the dff's d pin: synchronize, debounce, and report edges and glitches.
//  clk        in   rising-edge clock
//  reset      in   asynchronous, active-high
//  d_raw      in   raw asynchronous input
//  en         in   sample enable for the FSM/counters (sync chain always runs)
//  d_out      out  debounced level
//  d_outb     out  ~d_out, continuously (also in reset)
//  rise       out  one-cycle pulse in the first cycle d_out==1
//  fall       out  one-cycle pulse in the first cycle d_out==0
//  stable     out  FSM idle at a committed level
//  glitch_cnt out  rejected candidate levels, saturating at 255
module d_input_conditioner
    import dff_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                d_raw,
    input  logic                en,
    output logic                d_out,
    output logic                d_outb,
    output logic                rise,
    output logic                fall,
    output logic                stable,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value reached on the sample just before the committing one.
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam cond_state_t      ST_RST  = RESET_VAL ? IDLE_HI : IDLE_LO;

    logic                sync_q;
    cond_state_t         state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                d_nx, rise_nx, fall_nx;
    logic [GLITCH_W-1:0] glitch_nx;

    dff_sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (d_raw),
        .dout  (sync_q)
    );

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        d_nx      = d_out;
        rise_nx   = 1'b0;
        fall_nx   = 1'b0;
        glitch_nx = glitch_cnt;
        if (en) begin
            unique case (state)
                IDLE_LO: if (sync_q) begin
                    // A single-sample debounce commits on first sight.
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nx = IDLE_HI;
                        d_nx     = 1'b1;
                        rise_nx  = 1'b1;
                    end else begin
                        state_nx = CHK_HI;
                        cnt_nx   = CNT_W'(1);
                    end
                end
                CHK_HI: begin
                    if (sync_q) begin
                        if (cnt == CNT_PRE) begin
                            state_nx = IDLE_HI;
                            cnt_nx   = '0;
                            d_nx     = 1'b1;
                            rise_nx  = 1'b1;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end else begin
                        state_nx  = IDLE_LO;
                        cnt_nx    = '0;
                        glitch_nx = sat_inc(glitch_cnt);
                    end
                end
                IDLE_HI: if (!sync_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nx = IDLE_LO;
                        d_nx     = 1'b0;
                        fall_nx  = 1'b1;
                    end else begin
                        state_nx = CHK_LO;
                        cnt_nx   = CNT_W'(1);
                    end
                end
                CHK_LO: begin
                    if (!sync_q) begin
                        if (cnt == CNT_PRE) begin
                            state_nx = IDLE_LO;
                            cnt_nx   = '0;
                            d_nx     = 1'b0;
                            fall_nx  = 1'b1;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end else begin
                        state_nx  = IDLE_HI;
                        cnt_nx    = '0;
                        glitch_nx = sat_inc(glitch_cnt);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RST;
            cnt        <= '0;
            d_out      <= RESET_VAL;
            rise       <= 1'b0;
            fall       <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            d_out      <= d_nx;
            rise       <= rise_nx;
            fall       <= fall_nx;
            glitch_cnt <= glitch_nx;
        end
    end

    assign d_outb = ~d_out;
    assign stable = (state == IDLE_LO) || (state == IDLE_HI);

endmodule

// File: tb/tb_d_input_conditioner.sv
module tb_d_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_raw;
    logic       en;
    logic [1:0] d_out, d_outb, rise, fall, stable;
    logic [7:0] gc [2];

    int total = 0;
    int bad   = 0;

    // Instance 0: defaults. Instance 1: reset-high, single-sample debounce.
    d_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .d_raw(d_raw), .en(en),
        .d_out(d_out[0]), .d_outb(d_outb[0]), .rise(rise[0]), .fall(fall[0]),
        .stable(stable[0]), .glitch_cnt(gc[0])
    );
    d_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .d_raw(d_raw), .en(en),
        .d_out(d_out[1]), .d_outb(d_outb[1]), .rise(rise[1]), .fall(fall[1]),
        .stable(stable[1]), .glitch_cnt(gc[1])
    );

    always #5 clk = ~clk;

    // Reference model: delay line for synchronization, then a run-length of
    // consecutive enabled samples disagreeing with the committed level.
    localparam int SYNC = 2;
    int         m_deb [2] = '{4, 1};
    logic       m_rv  [2] = '{1'b0, 1'b1};
    logic [SYNC-1:0] m_pipe [2];
    logic       m_lvl [2];
    logic       m_rise[2];
    logic       m_fall[2];
    int         m_run [2];
    int         m_gl  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pipe[k] = {SYNC{m_rv[k]}};
            m_lvl[k]  = m_rv[k];
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            m_run[k]  = 0;
            m_gl[k]   = 0;
        end
    endtask

    task automatic model_edge(input logic din, input logic ena);
        logic s;
        for (int k = 0; k < 2; k++) begin
            s = m_pipe[k][SYNC-1];
            m_pipe[k] = {m_pipe[k][SYNC-2:0], din};
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            if (ena) begin
                if (s != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == m_deb[k]) begin
                        m_lvl[k]  = s;
                        m_rise[k] = s;
                        m_fall[k] = ~s;
                        m_run[k]  = 0;
                    end
                end else if (m_run[k] > 0) begin
                    if (m_gl[k] < 255) m_gl[k]++;
                    m_run[k] = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s.d_out%0d", ph, k),  {31'd0, d_out[k]},  {31'd0, m_lvl[k]});
            check($sformatf("%s.d_outb%0d", ph, k), {31'd0, d_outb[k]}, {31'd0, ~m_lvl[k]});
            check($sformatf("%s.rise%0d", ph, k),   {31'd0, rise[k]},   {31'd0, m_rise[k]});
            check($sformatf("%s.fall%0d", ph, k),   {31'd0, fall[k]},   {31'd0, m_fall[k]});
            check($sformatf("%s.stable%0d", ph, k), {31'd0, stable[k]}, {31'd0, m_run[k] == 0});
            check($sformatf("%s.glitch%0d", ph, k), {24'd0, gc[k]},     m_gl[k]);
        end
    endtask

    // One clock: inputs are stable across the edge; outputs checked 1ns later.
    task automatic tick(input string ph);
        logic din, ena;
        din = d_raw;
        ena = en;
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge(din, ena);
        #1;
        check_all(ph);
    endtask

    task automatic async_reset(input string ph);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(ph);
    endtask

    initial begin
        // 1. Reset with unknown input.
        reset = 1'b1;
        d_raw = 1'bx;
        en    = 1'b1;
        #2;
        model_reset();
        check_all("rst");
        check("rst.d_out0", {31'd0, d_out[0]}, 32'd0);
        check("rst.d_outb0", {31'd0, d_outb[0]}, 32'd1);
        tick("rst");
        tick("rst");

        // 2. Release, hold d_raw=1: commit at edge 6.
        reset = 1'b0;
        d_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick("lat");
            if (e >= 3 && e <= 5) check($sformatf("lat.stable_e%0d", e), {31'd0, stable[0]}, 32'd0);
            if (e == 5) check("lat.d_out_e5", {31'd0, d_out[0]}, 32'd0);
            if (e == 6) begin
                check("lat.d_out_e6", {31'd0, d_out[0]}, 32'd1);
                check("lat.rise_e6", {31'd0, rise[0]}, 32'd1);
            end
            if (e == 7) check("lat.rise_e7", {31'd0, rise[0]}, 32'd0);
        end

        // 3. Return low, then short pulses that reach CHK_HI but never commit.
        d_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick("low");
        for (int n = 0; n < 300; n++) begin
            d_raw = 1'b1;
            for (int i = 0; i < 3; i++) tick("gl");
            d_raw = 1'b0;
            for (int i = 0; i < 5; i++) tick("gl");
            if (n == 0) check("gl.first", {24'd0, gc[0]}, 32'd1);
        end
        check("gl.sat", {24'd0, gc[0]}, 32'd255);
        check("gl.d_out", {31'd0, d_out[0]}, 32'd0);

        // 4. Toggling enable stretches the debounce window.
        d_raw = 1'b1;
        for (int i = 0; i < 16; i++) begin
            en = (i % 2 == 0);
            tick("en");
        end
        en = 1'b1;
        check("en.commit", {31'd0, d_out[0]}, 32'd1);

        // 5. Reset while mid-debounce (CHK_HI, cnt=2), release with d_raw=0.
        d_raw = 1'b0;
        for (int i = 0; i < 10; i++) tick("pre5");
        d_raw = 1'b1;
        for (int i = 0; i < 4; i++) tick("chk");
        check("chk.unstable", {31'd0, stable[0]}, 32'd0);
        async_reset("arst");
        check("arst.d_out0", {31'd0, d_out[0]}, 32'd0);
        check("arst.stable0", {31'd0, stable[0]}, 32'd1);
        tick("arst");
        reset = 1'b0;
        d_raw = 1'b0;
        // 6. Instance 1 (reset high, debounce 1) falls at edge 3.
        for (int e = 1; e <= 6; e++) begin
            tick("rel");
            check($sformatf("rel.rise0_e%0d", e), {31'd0, rise[0]}, 32'd0);
            if (e == 2) check("rel.d_out1_e2", {31'd0, d_out[1]}, 32'd1);
            if (e == 3) begin
                check("rel.d_out1_e3", {31'd0, d_out[1]}, 32'd0);
                check("rel.fall1_e3", {31'd0, fall[1]}, 32'd1);
                check("rel.d_outb1_e3", {31'd0, d_outb[1]}, 32'd1);
            end
            if (e == 4) check("rel.fall1_e4", {31'd0, fall[1]}, 32'd0);
        end

        // 7. Random bouncing with random enable and rare async resets.
        for (int n = 0; n < 600; n++) begin
            d_raw = 1'($urandom_range(0, 1));
            for (int i = 0, len = $urandom_range(1, 8); i < len; i++) begin
                en = ($urandom_range(0, 3) != 0);
                tick("rnd");
            end
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd.rst");
                tick("rnd.rst");
                reset = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
